// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------------------
// if_id_queue
//   Instruction queue between the fetch (IF) and decode (ID) stages. Buffers {pc, instr}
//   pairs from IF and presents them to ID in order. Drives IF's hlt input as backpressure
//   and flushes on a control-flow redirect (the same pulse that drives IF's useAlt).
//
// Parameters
//   DEPTH   queue entries; power of two, >= 2
//   SKID    free slots left when ifHlt asserts; covers the synchronous IM read lag
//
// Ports
//   clk      in   clock, all state changes on posedge
//   nRst     in   asynchronous reset, active low
//   ifValid  in   ifPc/ifInstr hold a fetched pair this cycle
//   ifPc     in   PC of the fetched instruction
//   ifInstr  in   fetched instruction word
//   ifHlt    out  freeze the IF PC
//   flush    in   redirect pulse; discards all entries at the next edge
//   idStall  in   ID cannot accept this cycle
//   idValid  out  idPc/idInstr valid
//   idPc     out  head entry PC (0 when empty)
//   idInstr  out  head entry instruction (0 when empty)
//   count    out  current occupancy, 0..DEPTH
//   ovfErr   out  sticky: push attempted while full with no pop
//
// Configuration
//   IFQ_BYPASS_EN  when defined, an empty queue forwards ifPc/ifInstr straight to ID in
//                  the same cycle; the entry is only written if ID stalls.
// ----------------------------------------------------------------------------------------
module if_id_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned SKID  = 1
) (
   input  logic                     clk,
   input  logic                     nRst,
   input  logic                     ifValid,
   input  logic [15:0]              ifPc,
   input  logic [15:0]              ifInstr,
   output logic                     ifHlt,
   input  logic                     flush,
   input  logic                     idStall,
   output logic                     idValid,
   output logic [15:0]              idPc,
   output logic [15:0]              idInstr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovfErr
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FullLevel = CW'(DEPTH);
   localparam logic [CW-1:0] HltLevel  = CW'(DEPTH - SKID);

   logic [15:0]   mem_pc    [DEPTH];
   logic [15:0]   mem_instr [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic          not_empty;
   logic          full;
   logic          bypass;
   logic          byp_take;
   logic          push;
   logic          pop;
   logic          do_rd;
   logic          do_wr;

   always_comb begin
      not_empty = (count_q != '0);
      full      = (count_q == FullLevel);
`ifdef IFQ_BYPASS_EN
      bypass    = ~not_empty & ifValid & ~flush;
`else
      bypass    = 1'b0;
`endif

      // Head path: stored entry first, then the bypassed fetch, else zeros
      idValid = not_empty | bypass;
      if (not_empty) begin
         idPc    = mem_pc[rd_ptr_q];
         idInstr = mem_instr[rd_ptr_q];
      end else if (bypass) begin
         idPc    = ifPc;
         idInstr = ifInstr;
      end else begin
         idPc    = 16'd0;
         idInstr = 16'd0;
      end

      push     = ifValid & ~flush;
      pop      = idValid & ~idStall & ~flush;
      // A bypassed entry consumed by ID never lands in storage
      byp_take = bypass & ~idStall;
      do_rd    = pop & not_empty;
      // Full is still writable when the head leaves in the same cycle
      do_wr    = push & ~byp_take & (~full | do_rd);

      ovf_d    = ovf_q | (push & full & ~do_rd);

      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
         if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_wr && !do_rd) count_d = count_q + CW'(1);
         else if (do_rd && !do_wr) count_d = count_q - CW'(1);
      end

      ifHlt  = (count_q >= HltLevel) & ~flush;
      count  = count_q;
      ovfErr = ovf_q;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_pc[wr_ptr_q]    <= ifPc;
         mem_instr[wr_ptr_q] <= ifInstr;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned SKID  = 1;

   logic        clk = 1'b0;
   logic        nRst;
   logic        ifValid;
   logic [15:0] ifPc;
   logic [15:0] ifInstr;
   logic        ifHlt;
   logic        flush;
   logic        idStall;
   logic        idValid;
   logic [15:0] idPc;
   logic [15:0] idInstr;
   logic [2:0]  count;
   logic        ovfErr;

   if_id_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
      .clk     (clk),
      .nRst    (nRst),
      .ifValid (ifValid),
      .ifPc    (ifPc),
      .ifInstr (ifInstr),
      .ifHlt   (ifHlt),
      .flush   (flush),
      .idStall (idStall),
      .idValid (idValid),
      .idPc    (idPc),
      .idInstr (idInstr),
      .count   (count),
      .ovfErr  (ovfErr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: an ordered list of {pc, instr} and a sticky overflow flag
   logic [31:0] mq[$];
   bit          m_ovf;

   bit          track_rx = 0;
   int          rx_next  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a negedge; drives inputs, checks outputs just before posedge, steps the model
   task automatic cycle(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                        input logic f, input logic s);
      bit          byp;
      bit          exp_valid;
      bit          do_pop;
      logic [15:0] exp_pc, exp_ins;
      int          sz;
      ifValid = v; ifPc = pc; ifInstr = ins; flush = f; idStall = s;
      #4;
      sz  = mq.size();
`ifdef IFQ_BYPASS_EN
      byp = (sz == 0) && v && !f;
`else
      byp = 0;
`endif
      exp_valid = (sz != 0) || byp;
      if (sz != 0) begin
         exp_pc  = mq[0][31:16];
         exp_ins = mq[0][15:0];
      end else if (byp) begin
         exp_pc  = pc;
         exp_ins = ins;
      end else begin
         exp_pc  = 16'd0;
         exp_ins = 16'd0;
      end
      check("idValid", {31'd0, idValid}, {31'd0, exp_valid});
      check("idPc", {16'd0, idPc}, {16'd0, exp_pc});
      check("idInstr", {16'd0, idInstr}, {16'd0, exp_ins});
      check("count", {29'd0, count}, sz);
      check("ifHlt", {31'd0, ifHlt}, {31'd0, (sz >= int'(DEPTH - SKID)) && !f});
      check("ovfErr", {31'd0, ovfErr}, {31'd0, m_ovf});
      do_pop = exp_valid && !s && !f;
      if (track_rx && do_pop) begin
         check("order", {16'd0, idPc}, rx_next);
         rx_next++;
      end
      @(posedge clk);
      if (f) begin
         mq.delete();
      end else if (byp) begin
         if (s) mq.push_back({pc, ins});
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (v) begin
            if (sz == int'(DEPTH) && !do_pop) m_ovf = 1;
            else mq.push_back({pc, ins});
         end
      end
      @(negedge clk);
   endtask

   // Asserts reset mid-cycle (away from the edge) and checks the outputs respond at once
   task automatic do_reset();
      ifValid = 0; flush = 0; idStall = 1; ifPc = 0; ifInstr = 0;
      nRst = 0;
      mq.delete();
      m_ovf = 0;
      #1;
      check("rst_idValid", {31'd0, idValid}, 0);
      check("rst_idPc", {16'd0, idPc}, 0);
      check("rst_count", {29'd0, count}, 0);
      check("rst_ifHlt", {31'd0, ifHlt}, 0);
      check("rst_ovfErr", {31'd0, ovfErr}, 0);
      #2 nRst = 1;
      @(negedge clk);
   endtask

   initial begin
      int pc_next;
      int guard;
      nRst = 1; ifValid = 0; flush = 0; idStall = 1; ifPc = 0; ifInstr = 0;
      m_ovf = 0;
      @(negedge clk);
      do_reset();

      // Reset mid-stream with three entries held
      for (int i = 0; i < 3; i++) cycle(1, 16'h0100 + 16'(i), 16'h1111, 0, 1);
      check("pre_rst_count", {29'd0, count}, 3);
      do_reset();

      // Empty queue, push with ID ready: visible next cycle (or same cycle with bypass)
      cycle(1, 16'h0040, 16'hA5A5, 0, 0);
      cycle(0, 16'h0, 16'h0, 0, 1);
      cycle(0, 16'h0, 16'h0, 0, 0);
      cycle(0, 16'h0, 16'h0, 0, 0);

      // Flush with simultaneous push and pop from count=2
      cycle(1, 16'h0200, 16'h2222, 0, 1);
      cycle(1, 16'h0201, 16'h2223, 0, 1);
      cycle(1, 16'h0202, 16'h2224, 1, 0);
      check("post_flush_count", {29'd0, count}, 0);
      check("post_flush_valid", {31'd0, idValid}, 0);
      cycle(0, 16'h0, 16'h0, 0, 0);

      // Fill to full, then overflow
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 16'h0010 + 16'(i), 16'h3000 + 16'(i), 0, 1);
      check("full_count", {29'd0, count}, 4);
      check("full_ovf", {31'd0, ovfErr}, 0);
      cycle(1, 16'h0014, 16'h3004, 0, 1);
      check("ovf_set", {31'd0, ovfErr}, 1);
      check("ovf_head", {16'd0, idPc}, 16'h0010);
      check("ovf_count", {29'd0, count}, 4);
      // Push and pop together while full
      cycle(1, 16'h0015, 16'h3005, 0, 0);
      cycle(0, 16'h0, 16'h0, 0, 1);

      // Ordered stream with stall toggling; IF respects the halt threshold
      do_reset();
      track_rx = 1; rx_next = 0; pc_next = 0; guard = 0;
      while (rx_next < 10 && guard < 100) begin
         logic v;
         v = (pc_next < 10) && (mq.size() < int'(DEPTH - SKID));
         cycle(v, 16'(pc_next), 16'h5A00 + 16'(pc_next), 0, guard[0]);
         if (v) pc_next++;
         guard++;
      end
      track_rx = 0;
      check("order_done", rx_next, 10);

      // Randomized traffic; IF occasionally ignores ifHlt to provoke drops
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic v, f, s;
         v = ($urandom_range(0, 3) != 0);
         if (mq.size() >= int'(DEPTH - SKID) && $urandom_range(0, 3) != 0) v = 0;
         f = ($urandom_range(0, 15) == 0);
         s = ($urandom_range(0, 1) == 1);
         cycle(v, 16'($urandom), 16'($urandom), f, s);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
